// File: rtl/buffer_mux_pkg.sv
// Shared types and constants for the 16:1 buffer-and-mux arbiter.
//   NUM_REQ       : number of requesters (fixed by the mux width)
//   SEL_W         : width of a binary requester index
//   MAX_BURST_DEF : default beats per grant before forced re-arbitration
package buffer_mux_pkg;

  localparam int unsigned NUM_REQ       = 16;
  localparam int unsigned SEL_W         = 4;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary index of a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set bit of req_i searching ptr_i+1, ptr_i+2, ...
// wrapping 15->0, so ptr_i itself is considered last.
//   req_i  : request vector
//   ptr_i  : index of the previous winner
//   pick_o : one-hot winner (0 when no request)
//   any_o  : at least one request present
module rr_priority_pick
  import buffer_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               any_o
);

  logic [SEL_W-1:0] idx;

  // Walk the rotated order; the 4-bit index wraps naturally.
  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ptr_i + SEL_W'(k);
      if (!any_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_mux_arbiter.sv
// Round-robin arbiter/sequencer driving the one-hot mux_sel of the 32-bit
// 16:1 registered buffer. Grants are bounded to MAX_BURST beats; each beat
// is flagged one cycle later on out_valid/out_src, aligned with data_out.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-requester request
//   out_ready  : downstream accepts a word this cycle
//   mux_sel    : one-hot buffer select (0 = no source)
//   grant      : copy of mux_sel
//   beat_ack   : one-hot, combinational, owner's word taken this cycle
//   out_valid  : buffer data_out holds a transferred word
//   out_src    : index of the source of that word
//   busy       : arbiter is in GRANT
module buffer_mux_arbiter
  import buffer_mux_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned BURST_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] mux_sel,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] beat_ack,
  output logic               out_valid,
  output logic [SEL_W-1:0]   out_src,
  output logic               busy
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               out_valid_q;
  logic [SEL_W-1:0]   out_src_q;

  logic [SEL_W-1:0]   owner;
  logic               owner_req;
  logic               beat_c;
  logic               rel_drop;
  logic               rel_burst;
  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick;
  logic               pick_any;

  assign owner     = onehot_to_idx(sel_q);
  assign owner_req = |(sel_q & req);
  assign beat_c    = owner_req & out_ready;
  assign rel_drop  = (state_q == GRANT) & ~owner_req;
  assign rel_burst = beat_c & (cnt_q == BURST_W'(MAX_BURST - 1));

  // In IDLE arbitrate from the stored pointer; in GRANT from the current
  // owner, excluding it when it has dropped its request.
  assign pick_req = (state_q == GRANT && rel_drop) ? (req & ~sel_q) : req;
  assign pick_ptr = (state_q == GRANT) ? owner : ptr_q;

  rr_priority_pick u_pick (
    .req_i  (pick_req),
    .ptr_i  (pick_ptr),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  // Next-state: grant, beat counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          sel_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel_drop || rel_burst) begin
          // Hand over directly, no dead cycle between grants.
          ptr_d = owner;
          cnt_d = '0;
          sel_d = pick;
          if (!pick_any) state_d = IDLE;
        end else if (beat_c) begin
          cnt_d = cnt_q + BURST_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= SEL_W'(NUM_REQ - 1);
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= beat_c;
      out_src_q   <= beat_c ? owner : '0;
    end
  end

  assign mux_sel   = sel_q;
  assign grant     = sel_q;
  assign beat_ack  = sel_q & req & {NUM_REQ{out_ready}};
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == GRANT);

`ifndef SYNTHESIS
  a_sel_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel_q));
  a_valid_beat:  assert property (@(posedge clk) disable iff (!rst_n) out_valid_q |-> $past(beat_c));
`endif

endmodule

// File: tb/tb_buffer_mux_arbiter.sv
// Directed and randomized checks for buffer_mux_arbiter.
module tb_buffer_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        out_ready;
  logic [15:0] mux_sel;
  logic [15:0] grant;
  logic [15:0] beat_ack;
  logic        out_valid;
  logic [3:0]  out_src;
  logic        busy;

  int checks = 0;
  int errors = 0;

  buffer_mux_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .mux_sel   (mux_sel),
    .grant     (grant),
    .beat_ack  (beat_ack),
    .out_valid (out_valid),
    .out_src   (out_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] r, input logic rd);
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1; req = r; out_ready = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (mux_sel !== 16'h0) begin errors++; $display("FAIL reset_mux_sel: got %h expected 0000", mux_sel); end
    checks++; if (grant !== 16'h0) begin errors++; $display("FAIL reset_grant: got %h expected 0000", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_src !== 4'd0) begin errors++; $display("FAIL reset_out_src: got %0d expected 0", out_src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (beat_ack !== 16'h0) begin errors++; $display("FAIL reset_beat_ack: got %h expected 0000", beat_ack); end
  endtask

  // Sole requester 0: continuous grant across burst boundaries.
  task automatic test_single();
    do_reset(16'h0001, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (mux_sel !== 16'h0001) begin errors++; $display("FAIL single_mux_sel k=%0d: got %h expected 0001", k, mux_sel); end
      checks++; if (out_valid !== (k >= 2)) begin errors++; $display("FAIL single_out_valid k=%0d: got %b expected %b", k, out_valid, (k >= 2)); end
      if (k >= 2) begin
        checks++; if (out_src !== 4'd0) begin errors++; $display("FAIL single_out_src k=%0d: got %0d expected 0", k, out_src); end
      end
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      end
      #1;
      checks++; if (beat_ack !== 16'h0001) begin errors++; $display("FAIL single_beat_ack k=%0d: got %h expected 0001", k, beat_ack); end
    end
  endtask

  // Requesters 0 and 15 alternate, 4 beats each.
  task automatic test_alternate();
    logic [15:0] exp_sel;
    logic [3:0]  exp_src;
    do_reset(16'h8001, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_sel = (((k - 1) / 4) % 2 == 0) ? 16'h0001 : 16'h8000;
      checks++; if (mux_sel !== exp_sel) begin errors++; $display("FAIL alt_mux_sel k=%0d: got %h expected %h", k, mux_sel, exp_sel); end
      if (k >= 2) begin
        exp_src = (((k - 2) / 4) % 2 == 0) ? 4'd0 : 4'd15;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alt_out_valid k=%0d: got %b expected 1", k, out_valid); end
        checks++; if (out_src !== exp_src) begin errors++; $display("FAIL alt_out_src k=%0d: got %0d expected %0d", k, out_src, exp_src); end
      end
    end
  endtask

  // Owner 3 drops after 2 beats; 7 takes over at once with a fresh count.
  task automatic test_drop();
    logic [15:0] t_sel [9];
    logic        t_ov  [9];
    logic [3:0]  t_src [9];
    logic [15:0] t_req [9];
    logic [15:0] t_ack [9];
    t_sel = '{16'h08, 16'h08, 16'h08, 16'h80, 16'h80, 16'h80, 16'h80, 16'h08, 16'h08};
    t_ov  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t_src = '{4'd0, 4'd3, 4'd3, 4'd0, 4'd7, 4'd7, 4'd7, 4'd7, 4'd3};
    t_req = '{16'h88, 16'h88, 16'h80, 16'h88, 16'h88, 16'h88, 16'h88, 16'h88, 16'h88};
    t_ack = '{16'h08, 16'h08, 16'h00, 16'h80, 16'h80, 16'h80, 16'h80, 16'h08, 16'h08};
    do_reset(16'h0088, 1'b1);
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (mux_sel !== t_sel[k]) begin errors++; $display("FAIL drop_mux_sel k=%0d: got %h expected %h", k + 1, mux_sel, t_sel[k]); end
      checks++; if (out_valid !== t_ov[k]) begin errors++; $display("FAIL drop_out_valid k=%0d: got %b expected %b", k + 1, out_valid, t_ov[k]); end
      if (t_ov[k]) begin
        checks++; if (out_src !== t_src[k]) begin errors++; $display("FAIL drop_out_src k=%0d: got %0d expected %0d", k + 1, out_src, t_src[k]); end
      end
      req = t_req[k];
      #1;
      checks++; if (beat_ack !== t_ack[k]) begin errors++; $display("FAIL drop_beat_ack k=%0d: got %h expected %h", k + 1, beat_ack, t_ack[k]); end
    end
  endtask

  // out_ready low for 3 cycles mid-burst; burst still delivers 4 beats.
  task automatic test_stall();
    logic [15:0] t_sel [9];
    logic        t_ov  [9];
    logic [3:0]  t_src [9];
    logic        t_rdy [9];
    logic [15:0] t_ack [9];
    t_sel = '{16'h04, 16'h04, 16'h04, 16'h04, 16'h04, 16'h04, 16'h04, 16'h10, 16'h10};
    t_ov  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_src = '{4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd4};
    t_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_ack = '{16'h04, 16'h04, 16'h00, 16'h00, 16'h00, 16'h04, 16'h04, 16'h10, 16'h10};
    do_reset(16'h0014, 1'b1);
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (mux_sel !== t_sel[k]) begin errors++; $display("FAIL stall_mux_sel k=%0d: got %h expected %h", k + 1, mux_sel, t_sel[k]); end
      checks++; if (out_valid !== t_ov[k]) begin errors++; $display("FAIL stall_out_valid k=%0d: got %b expected %b", k + 1, out_valid, t_ov[k]); end
      if (t_ov[k]) begin
        checks++; if (out_src !== t_src[k]) begin errors++; $display("FAIL stall_out_src k=%0d: got %0d expected %0d", k + 1, out_src, t_src[k]); end
      end
      out_ready = t_rdy[k];
      #1;
      checks++; if (beat_ack !== t_ack[k]) begin errors++; $display("FAIL stall_beat_ack k=%0d: got %h expected %h", k + 1, beat_ack, t_ack[k]); end
    end
  endtask

  // Reset mid-burst of requester 5, then req0 wins first.
  task automatic test_reset_mid_burst();
    do_reset(16'h0020, 1'b1);
    tick();
    tick();
    checks++; if (mux_sel !== 16'h0020) begin errors++; $display("FAIL rstmid_pre_mux_sel: got %h expected 0020", mux_sel); end
    rst_n = 1'b0; req = 16'h0021;
    tick();
    checks++; if (mux_sel !== 16'h0) begin errors++; $display("FAIL rstmid_mux_sel: got %h expected 0000", mux_sel); end
    checks++; if (grant !== 16'h0) begin errors++; $display("FAIL rstmid_grant: got %h expected 0000", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_src !== 4'd0) begin errors++; $display("FAIL rstmid_out_src: got %0d expected 0", out_src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (beat_ack !== 16'h0) begin errors++; $display("FAIL rstmid_beat_ack: got %h expected 0000", beat_ack); end
    rst_n = 1'b1;
    tick();
    checks++; if (mux_sel !== 16'h0001) begin errors++; $display("FAIL rstmid_first_winner: got %h expected 0001", mux_sel); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_src !== 4'd0) begin errors++; $display("FAIL rstmid_first_word: got valid=%b src=%0d expected valid=1 src=0", out_valid, out_src); end
  endtask

  function automatic logic [15:0] m_pick(input logic [15:0] r, input int p);
    logic [15:0] res;
    int j;
    res = '0;
    for (int i = 1; i <= 16; i++) begin
      j = (p + i) % 16;
      if (r[j] && res == 16'h0) res[j] = 1'b1;
    end
    return res;
  endfunction

  function automatic int m_idx(input logic [15:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (s[i]) n = i;
    return n;
  endfunction

  // Random requesters (hold until served) and out_ready vs a reference model.
  task automatic test_random();
    logic [15:0] m_sel, r, m_beat, last_ack, cur_sel;
    logic        m_ov, rdy, rel_a, rel_b;
    logic [3:0]  m_src;
    int          m_cnt, m_ptr, o;
    int          wait_b [16];
    int          max_wait [16];
    do_reset(16'h0, 1'b0);
    m_sel = '0; m_cnt = 0; m_ptr = 15; m_ov = 1'b0; m_src = '0;
    r = '0; last_ack = '0;
    for (int i = 0; i < 16; i++) begin wait_b[i] = 0; max_wait[i] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 16; i++) begin
        if (!r[i]) r[i] = ($urandom_range(3) == 0);
        else if (last_ack[i]) r[i] = ($urandom_range(3) != 0);
      end
      rdy = ($urandom_range(3) != 0);
      req = r; out_ready = rdy;
      #1;
      m_beat = m_sel & r & {16{rdy}};
      checks++; if (beat_ack !== m_beat) begin errors++; $display("FAIL rand_beat_ack c=%0d: got %h expected %h", c, beat_ack, m_beat); end
      last_ack = m_beat;
      cur_sel = m_sel;
      for (int i = 0; i < 16; i++) begin
        if (!r[i] || cur_sel[i]) wait_b[i] = 0;
        else if (m_beat != 16'h0) wait_b[i]++;
        if (wait_b[i] > max_wait[i]) max_wait[i] = wait_b[i];
      end
      o = m_idx(m_sel);
      m_ov  = (m_beat != 16'h0);
      m_src = m_ov ? 4'(o) : 4'd0;
      if (m_sel == 16'h0) begin
        if (r != 16'h0) m_sel = m_pick(r, m_ptr);
        m_cnt = 0;
      end else begin
        rel_a = !r[o];
        rel_b = (m_beat != 16'h0) && (m_cnt == 3);
        if (rel_a || rel_b) begin
          m_sel = m_pick(rel_a ? (r & ~cur_sel) : r, o);
          m_ptr = o;
          m_cnt = 0;
        end else if (m_beat != 16'h0) begin
          m_cnt++;
        end
      end
      tick();
      checks++; if (mux_sel !== m_sel) begin errors++; $display("FAIL rand_mux_sel c=%0d: got %h expected %h", c, mux_sel, m_sel); end
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_out_valid c=%0d: got %b expected %b", c, out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (out_src !== m_src) begin errors++; $display("FAIL rand_out_src c=%0d: got %0d expected %0d", c, out_src, m_src); end
      end
      checks++; if (busy !== (m_sel != 16'h0)) begin errors++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, (m_sel != 16'h0)); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (max_wait[i] > 60) begin errors++; $display("FAIL rand_starvation req=%0d: waited %0d beats, limit 60", i, max_wait[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
